// File: rtl/watch_pkg.sv
// Shared calendar constants, time-of-day record and month-length helper
// used by the RTC timekeeper and its bench.
package watch_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

  localparam logic [7:0] SEC_MAX   = 8'd59;
  localparam logic [7:0] MIN_MAX   = 8'd59;
  localparam logic [7:0] HOUR_MAX  = 8'd23;
  localparam logic [7:0] MONTH_MAX = 8'd12;
  localparam logic [7:0] YEAR_MAX  = 8'd99;

  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
  } rtc_time_t;

  localparam rtc_time_t RESET_TIME = '{year: 8'd0, month: 8'd1, day: 8'd1,
                                       hour: 8'd0, minute: 8'd0, second: 8'd0};

  // Every year divisible by 4 is a leap year within 2000..2099.
  function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                               input logic [7:0] year);
    logic [7:0] days;
    case (month)
      8'd2:                     days = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11:  days = 8'd30;
      default:                  days = 8'd31;
    endcase
    return days;
  endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Load/readout bundle of the RTC timekeeper: set strobe with load values,
// registered calendar fields and status pulses.
interface rtc_timekeeper_if;
  logic       set_en;
  logic [7:0] set_year;
  logic [7:0] set_month;
  logic [7:0] set_day;
  logic [7:0] set_hour;
  logic [7:0] set_minute;
  logic [7:0] set_second;

  logic [7:0] year;
  logic [7:0] month;
  logic [7:0] day;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       tick;
  logic       set_err;

  modport master (
    output set_en, set_year, set_month, set_day, set_hour, set_minute, set_second,
    input  year, month, day, hour, minute, second, tick, set_err
  );

  modport slave (
    input  set_en, set_year, set_month, set_day, set_hour, set_minute, set_second,
    output year, month, day, hour, minute, second, tick, set_err
  );
endinterface

// File: rtl/rtc_prescaler.sv
// Divides clk down to one-second steps: counts 0..CLK_HZ-1 and flags the
// wrapping cycle; clr restarts the count and suppresses that cycle's flag.
module rtc_prescaler #(
  parameter int unsigned CLK_HZ = watch_pkg::CLK_HZ_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    wrap  = (cnt_q == CNT_LAST);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    tick  = wrap;
    if (clr) begin
      cnt_d = '0;
      tick  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// Calendar clock 2000..2099: validated one-shot loads, one-second advance
// through a second/minute/hour/day/month/year carry cascade.
module rtc_timekeeper
  import watch_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  rtc_timekeeper_if.slave bus
);

  rtc_time_t  time_q, time_d;
  rtc_time_t  set_val;
  logic       tick_q, tick_d;
  logic       set_err_q, set_err_d;
  logic [7:0] set_days, cur_days;
  logic       set_valid, load, adv;

  assign set_val  = '{year: bus.set_year, month: bus.set_month, day: bus.set_day,
                      hour: bus.set_hour, minute: bus.set_minute, second: bus.set_second};
  assign set_days = days_in_month(bus.set_month, bus.set_year);
  assign cur_days = days_in_month(time_q.month, time_q.year);

  assign set_valid = (set_val.year <= YEAR_MAX) &&
                     (set_val.month >= 8'd1) && (set_val.month <= MONTH_MAX) &&
                     (set_val.day >= 8'd1) && (set_val.day <= set_days) &&
                     (set_val.hour <= HOUR_MAX) &&
                     (set_val.minute <= MIN_MAX) &&
                     (set_val.second <= SEC_MAX);

  // A rejected load must not disturb the running second, so only valid loads clear.
  assign load = bus.set_en && set_valid;

  rtc_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .tick (adv)
  );

  always_comb begin
    time_d    = time_q;
    tick_d    = adv;
    set_err_d = bus.set_en && !set_valid;
    if (load) begin
      time_d = set_val;
    end else if (adv) begin
      if (time_q.second != SEC_MAX) begin
        time_d.second = time_q.second + 8'd1;
      end else begin
        time_d.second = 8'd0;
        if (time_q.minute != MIN_MAX) begin
          time_d.minute = time_q.minute + 8'd1;
        end else begin
          time_d.minute = 8'd0;
          if (time_q.hour != HOUR_MAX) begin
            time_d.hour = time_q.hour + 8'd1;
          end else begin
            time_d.hour = 8'd0;
            if (time_q.day != cur_days) begin
              time_d.day = time_q.day + 8'd1;
            end else begin
              time_d.day = 8'd1;
              if (time_q.month != MONTH_MAX) begin
                time_d.month = time_q.month + 8'd1;
              end else begin
                time_d.month = 8'd1;
                time_d.year  = (time_q.year == YEAR_MAX) ? 8'd0 : time_q.year + 8'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q    <= RESET_TIME;
      tick_q    <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      time_q    <= time_d;
      tick_q    <= tick_d;
      set_err_q <= set_err_d;
    end
  end

  assign bus.year    = time_q.year;
  assign bus.month   = time_q.month;
  assign bus.day     = time_q.day;
  assign bus.hour    = time_q.hour;
  assign bus.minute  = time_q.minute;
  assign bus.second  = time_q.second;
  assign bus.tick    = tick_q;
  assign bus.set_err = set_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper at CLK_HZ=4: expected snapshots are queued
// as stimulus is applied and compared against the outputs on the next falling edge.
module tb_rtc_timekeeper;
  import watch_pkg::*;

  typedef struct {
    rtc_time_t t;
    logic      tick;
    logic      err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  rtc_timekeeper_if bus ();

  rtc_timekeeper #(.CLK_HZ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int y, input int mo, input int d, input int h,
                              input int mi, input int s, input logic tk, input logic er);
    exp_t e;
    e.t    = '{year: 8'(y), month: 8'(mo), day: 8'(d), hour: 8'(h), minute: 8'(mi), second: 8'(s)};
    e.tick = tk;
    e.err  = er;
    return e;
  endfunction

  task automatic cmp(input string tag, input string field, input logic [7:0] obs,
                     input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    cmp(tag, "year",    bus.year,          e.t.year);
    cmp(tag, "month",   bus.month,         e.t.month);
    cmp(tag, "day",     bus.day,           e.t.day);
    cmp(tag, "hour",    bus.hour,          e.t.hour);
    cmp(tag, "minute",  bus.minute,        e.t.minute);
    cmp(tag, "second",  bus.second,        e.t.second);
    cmp(tag, "tick",    {7'd0, bus.tick},  {7'd0, e.tick});
    cmp(tag, "set_err", {7'd0, bus.set_err}, {7'd0, e.err});
  endtask

  // Queue the expectation, let one rising edge act on the current inputs, then compare.
  task automatic step(input exp_t e, input string tag);
    exp_q.push_back(e);
    @(negedge clk);
    check(tag);
  endtask

  task automatic drive_set(input int y, input int mo, input int d, input int h,
                           input int mi, input int s);
    bus.set_year   = 8'(y);
    bus.set_month  = 8'(mo);
    bus.set_day    = 8'(d);
    bus.set_hour   = 8'(h);
    bus.set_minute = 8'(mi);
    bus.set_second = 8'(s);
    bus.set_en     = 1'b1;
  endtask

  // After a load (prescaler at 0): three quiet cycles, then the tick with the advanced time.
  task automatic quiet_then_tick(input exp_t held, input exp_t next, input string tag);
    repeat (3) step(held, {tag, "_hold"});
    step(next, {tag, "_tick"});
  endtask

  initial begin
    rst = 1'b1;
    drive_set(0, 0, 0, 0, 0, 0);
    bus.set_en = 1'b0;
    repeat (2) @(negedge clk);
    step(mk(0, 1, 1, 0, 0, 0, 0, 0), "reset");

    // Free run: tick every 4th cycle, second counts up.
    rst = 1'b0;
    for (int k = 1; k <= 16; k++)
      step(mk(0, 1, 1, 0, 0, k / 4, (k % 4) == 0, 0), "run");

    // Non-leap February rollover.
    drive_set(23, 2, 28, 23, 59, 59);
    step(mk(23, 2, 28, 23, 59, 59, 0, 0), "set23");
    bus.set_en = 1'b0;
    quiet_then_tick(mk(23, 2, 28, 23, 59, 59, 0, 0), mk(23, 3, 1, 0, 0, 0, 1, 0), "feb23");

    // Leap February.
    drive_set(24, 2, 28, 23, 59, 59);
    step(mk(24, 2, 28, 23, 59, 59, 0, 0), "set24");
    bus.set_en = 1'b0;
    quiet_then_tick(mk(24, 2, 28, 23, 59, 59, 0, 0), mk(24, 2, 29, 0, 0, 0, 1, 0), "feb24");

    // Century wrap.
    drive_set(99, 12, 31, 23, 59, 59);
    step(mk(99, 12, 31, 23, 59, 59, 0, 0), "set99");
    bus.set_en = 1'b0;
    quiet_then_tick(mk(99, 12, 31, 23, 59, 59, 0, 0), mk(0, 1, 1, 0, 0, 0, 1, 0), "wrap99");

    // Rejected loads: fields untouched, prescaler keeps running.
    drive_set(5, 4, 31, 1, 1, 1);
    step(mk(0, 1, 1, 0, 0, 0, 0, 1), "bad_day");
    bus.set_en = 1'b0;
    step(mk(0, 1, 1, 0, 0, 0, 0, 0), "err_clear");
    drive_set(5, 5, 5, 5, 60, 5);
    step(mk(0, 1, 1, 0, 0, 0, 0, 1), "bad_min");
    bus.set_en = 1'b0;
    step(mk(0, 1, 1, 0, 0, 1, 1, 0), "tick_after_bad");

    // Load on the wrap cycle: no tick, count restarts.
    repeat (3) step(mk(0, 1, 1, 0, 0, 1, 0, 0), "pre_wrap");
    drive_set(10, 6, 15, 12, 30, 45);
    step(mk(10, 6, 15, 12, 30, 45, 0, 0), "wrap_set");
    bus.set_en = 1'b0;
    quiet_then_tick(mk(10, 6, 15, 12, 30, 45, 0, 0), mk(10, 6, 15, 12, 30, 46, 1, 0), "after_wrap");

    // Held strobe freezes time beyond a full tick period.
    drive_set(50, 7, 4, 8, 0, 0);
    repeat (6) step(mk(50, 7, 4, 8, 0, 0, 0, 0), "held");
    bus.set_en = 1'b0;
    quiet_then_tick(mk(50, 7, 4, 8, 0, 0, 0, 0), mk(50, 7, 4, 8, 0, 1, 1, 0), "after_held");

    // Reset mid-count with a valid load pending: reset wins.
    repeat (2) step(mk(50, 7, 4, 8, 0, 1, 0, 0), "pre_rst");
    rst = 1'b1;
    drive_set(12, 12, 12, 12, 12, 12);
    step(mk(0, 1, 1, 0, 0, 0, 0, 0), "rst_set");
    rst = 1'b0;
    bus.set_en = 1'b0;
    quiet_then_tick(mk(0, 1, 1, 0, 0, 0, 0, 0), mk(0, 1, 1, 0, 0, 1, 1, 0), "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_timekeeper.md
RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 Parameter: CLK_HZ, default 50_000_000, input clock frequency in Hz; one-second tick period in clk cycles.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: set_en  input  1  one-cycle load strobe for all set_* fields.
REQ-005 Port: set_year/set_month/set_day/set_hour/set_minute/set_second  input  8 each  binary load values.
REQ-006 Port: year  output  8  years since 2000, 0..99, binary.
REQ-007 Port: month  output  8  1..12, binary.
REQ-008 Port: day  output  8  1..days_in_month, binary.
REQ-009 Port: hour/minute/second  output  8 each  0..23 / 0..59 / 0..59, binary; directly drive bin2BCD.
REQ-010 Port: tick  output  1  one-cycle pulse on the cycle the time advances.
REQ-011 Port: set_err  output  1  one-cycle pulse the cycle after a rejected set_en.

Function
REQ-012 Prescaler counts 0..CLK_HZ-1; tick asserts for 1 cycle when it wraps to 0, giving exactly one tick per CLK_HZ cycles.
REQ-013 Time fields update in the same clock edge that registers tick (tick and new second visible together).
REQ-014 Cascade: second 59->0 carries minute; minute 59->0 carries hour; hour 23->0 carries day; day at days_in_month->1 carries month; month 12->1 carries year; year 99->0 wraps silently.
REQ-015 days_in_month: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February 29 if year[1:0]==0, else 28 (valid for 2000..2099).
REQ-016 set_en validation: all fields in range, month 1..12, day 1..days_in_month(set_month,set_year); invalid set leaves every field unchanged and pulses set_err next cycle.
REQ-017 Valid set_en: fields load on that edge; prescaler clears to 0; tick suppressed that cycle; next tick exactly CLK_HZ cycles later.
REQ-018 set_en coincident with prescaler wrap: set wins, no advance, no tick.
REQ-019 set_en held multiple cycles: each cycle reloads and re-clears prescaler; time frozen while held.
REQ-020 Outputs are registered; no combinational path from set_* to outputs.
REQ-021 Field state machine is implicit (counter cascade); no field ever holds an out-of-range value, including after reset and after any set attempt.

Reset
REQ-022 On rst: year=0, month=1, day=1, hour=0, minute=0, second=0, prescaler=0, tick=0, set_err=0.
REQ-023 rst has priority over set_en and tick; first tick after reset release occurs CLK_HZ cycles after the first cycle with rst low.
REQ-024 rst asserted mid-count discards partial prescaler count.

Structure
REQ-025 Shared package watch_pkg holds CLK_HZ default, field limits (SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12, YEAR_MAX=99) and the days_in_month function.
REQ-026 One sub-module rtc_prescaler (clk, rst, clr, tick) implements REQ-012/017; all calendar logic stays in rtc_timekeeper.
REQ-027 Prescaler width = clog2(CLK_HZ); field arithmetic in 8-bit unsigned.

Verification (bench uses CLK_HZ=4)
REQ-028 Reset release, run 16 clk -> exactly 4 tick pulses, 4 cycles apart; second=4, all else reset values.
REQ-029 Set 23-02-28 23:59:59, one tick -> 23-03-01 00:00:00; set 24-02-28 23:59:59, one tick -> 24-02-29 00:00:00.
REQ-030 Set 99-12-31 23:59:59, one tick -> 00-01-01 00:00:00.
REQ-031 Set day=31 month=4 -> set_err pulse next cycle, fields unchanged; set minute=60 -> set_err, unchanged.
REQ-032 set_en on prescaler-wrap cycle -> no tick, loaded value shown, next tick exactly 4 cycles later.
REQ-033 rst asserted 2 cycles into a count with set_en also high -> reset values, set ignored, next tick 4 cycles after rst falls.
